jk_input_conditioner: RTL
=========================

# jk_input_conditioner

Front-end stage for the `jk` flip-flop lab. It converts two raw active-low push-buttons into clean, single-cycle `J`/`K` command pulses on the flip-flop's clock. Each button path is synchronised, debounced and edge-detected. Presses of both buttons within a short window merge into one toggle command (`J=K=1`). The outputs drive `jk.J` and `jk.K` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); must be ≥2.
- `COMBINE_CYCLES`, default 250000: window, in cycles, in which a second press merges with the first; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `clc` in 1: asynchronous, active-low reset.
- `btn_j_n` in 1: raw J button, active-low, asynchronous to `clk`.
- `btn_k_n` in 1: raw K button, active-low, asynchronous to `clk`.
- `J` out 1: registered J command pulse, one cycle wide.
- `K` out 1: registered K command pulse, one cycle wide.
- `btn_j_db` out 1: debounced J level, 1 = pressed.
- `btn_k_db` out 1: debounced K level, 1 = pressed.
- `busy` out 1: high while the FSM is in WAIT or EMIT.

## Operation
- **Reset.** While `clc`=0, `J`=`K`=`btn_j_db`=`btn_k_db`=`busy`=0. Synchroniser flops read "released" (1). Counters are 0 and the state is IDLE. Asserting reset mid-operation discards any pending WAIT command; no pulse is emitted.
- **Synchroniser.** A 2-flop synchroniser on each raw input (see Configuration). Its output is inverted to active-high.
- **Debounce (per channel).**
  - The counter clears whenever the synchronised level equals the debounced level.
  - While they differ, the counter increments each cycle.
  - When the counter = `DEBOUNCE_CYCLES`-1 and the levels still differ, the debounced level flips on that edge and the counter clears.
  - The counter width is $clog2(`DEBOUNCE_CYCLES`) and it never wraps.
- **Press event.** A press event is a 0→1 transition of a debounced level, registered and one cycle wide. Releases generate no event.
- **FSM states.**
  - IDLE: both events in the same cycle → EMIT with cmd=11. One event → WAIT, latch cmd (J→10, K→01), timer=0.
  - WAIT: an event of the other button → EMIT with cmd=11. A repeat event of the latched button is ignored. When timer = `COMBINE_CYCLES`-1 → EMIT with the latched cmd. Otherwise timer++.
  - EMIT: `J`,`K` = cmd for exactly this cycle, then → IDLE unconditionally. Press events in the EMIT cycle are dropped.
- **No-command rule.** `J`/`K` are 0 in all states except EMIT. Command 00 (hold) is never emitted as a pulse.

## Timing
- Raw edge → debounced level change: 2 cycles (synchroniser) + `DEBOUNCE_CYCLES` cycles, provided the input is held stable throughout.
- Single press: `J` (or `K`) is high for one cycle, `COMBINE_CYCLES`+1 cycles after `btn_*_db` rises.
- Merged press: `J`=`K`=1 one cycle after the second press event, or one cycle after a same-cycle double event.
- `busy` rises one cycle after the first event and falls one cycle after the EMIT cycle.
- Outputs are fully registered; there is no combinational path from the inputs to any output.

## Configuration
- `JK_COND_SYNC_EN` defined: the 2-flop synchronisers are present and timing is as stated above.
- `JK_COND_SYNC_EN` undefined: the raw inputs feed the debouncers directly, inverted. All latencies shrink by 2 cycles. This build is for simulation and synchronous-stimulus benches only.

## Structure
- **Package `jk_pkg`** holds:
  - the state enum typedef (`IDLE`, `WAIT`, `EMIT`);
  - the 2-bit command constants `JK_HOLD`=00, `JK_RESET`=01, `JK_SET`=10, `JK_TOGGLE`=11.
- **Sub-module `jk_debounce`** (synchroniser + counter + level register), instantiated once per button. The FSM, event detection and output registers live in the top module.

## Test plan
Bench parameters are `DEBOUNCE_CYCLES`=4, `COMBINE_CYCLES`=8, with `JK_COND_SYNC_EN` defined.
- **Reset:** `clc`=0 mid-WAIT → `J`=`K`=`busy`=0 immediately; after release, no pulse appears for 20 cycles.
- **Clean J press:** `btn_j_n` low for 30 cycles → `btn_j_db` rises 6 cycles after the edge; `J`=1 and `K`=0 for exactly one cycle, 9 cycles later.
- **Bounce:** `btn_j_n` toggles every 2 cycles for 20 cycles, then is held high → `btn_j_db` stays 0 and no `J` pulse is produced.
- **Merge:** `btn_j_n` falls, then `btn_k_n` falls 3 cycles later → a single cycle with `J`=`K`=1, one cycle after the K event; no separate `J` pulse.
- **Late second press:** K event 12 cycles after the J event → a J-only pulse, followed later by a separate K-only pulse.
- **Same-cycle press:** both buttons fall on the same edge → `J`=`K`=1 one cycle after the events; `busy` is high for exactly 2 cycles.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared FSM state type and J/K command encodings for the jk flip-flop lab front end.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EMIT
    } jk_state_t;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jk_debounce.sv
// One button channel: optional 2-flop synchroniser (JK_COND_SYNC_EN), inversion to
// active-high, and a saturating stability counter that drives the debounced level.
module jk_debounce
    import jk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clc,
    input  logic btn_n,
    output logic level
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_lvl;
    logic [CW-1:0] cnt;

`ifdef JK_COND_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[0], btn_n};
        end
    end

    assign sync_lvl = ~sync_ff[1];
`else
    assign sync_lvl = ~btn_n;
`endif

    // Counter only runs while the input disagrees with the level, so it cannot wrap.
    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_lvl == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_lvl;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jk_input_conditioner.sv
// Turns two raw active-low buttons into single-cycle J/K command pulses, merging
// near-simultaneous presses into a toggle. Synchronisers enabled by JK_COND_SYNC_EN.
module jk_input_conditioner
    import jk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned COMBINE_CYCLES  = 250000
) (
    input  logic clk,
    input  logic clc,
    input  logic btn_j_n,
    input  logic btn_k_n,
    output logic J,
    output logic K,
    output logic btn_j_db,
    output logic btn_k_db,
    output logic busy
);

    localparam int unsigned   TW     = cnt_width(COMBINE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(COMBINE_CYCLES - 1);

    jk_state_t     state;
    logic [1:0]    cmd;
    logic [TW-1:0] timer;
    logic          db_j_q;
    logic          db_k_q;
    logic          ev_j;
    logic          ev_k;
    logic          ev_other;

    jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_j (
        .clk   (clk),
        .clc   (clc),
        .btn_n (btn_j_n),
        .level (btn_j_db)
    );

    jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_k (
        .clk   (clk),
        .clc   (clc),
        .btn_n (btn_k_n),
        .level (btn_k_db)
    );

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            db_j_q <= 1'b0;
            db_k_q <= 1'b0;
        end else begin
            db_j_q <= btn_j_db;
            db_k_q <= btn_k_db;
        end
    end

    // Press events are rising edges of the registered debounced levels only.
    assign ev_j     = btn_j_db & ~db_j_q;
    assign ev_k     = btn_k_db & ~db_k_q;
    assign ev_other = (cmd == JK_SET) ? ev_k : ev_j;

    // busy is held through the cycle after EMIT so it trails the command pulse.
    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            state <= IDLE;
            cmd   <= JK_HOLD;
            timer <= '0;
            J     <= 1'b0;
            K     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            J <= 1'b0;
            K <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= ev_j | ev_k;
                    if (ev_j && ev_k) begin
                        state  <= EMIT;
                        cmd    <= JK_TOGGLE;
                        {J, K} <= JK_TOGGLE;
                    end else if (ev_j) begin
                        state <= WAIT;
                        cmd   <= JK_SET;
                        timer <= '0;
                    end else if (ev_k) begin
                        state <= WAIT;
                        cmd   <= JK_RESET;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    busy <= 1'b1;
                    if (ev_other) begin
                        state  <= EMIT;
                        cmd    <= JK_TOGGLE;
                        {J, K} <= JK_TOGGLE;
                    end else if (timer == T_LAST) begin
                        state  <= EMIT;
                        {J, K} <= cmd;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                EMIT: begin
                    busy  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
